// File: rtl/heap_feeder_if.sv
// Upstream item stream into the heap feeder.
//   s_valid   : item present (source drives)
//   s_ready   : item accepted this cycle when high with s_valid (feeder drives)
//   s_key     : sort key
//   s_payload : item tag/index
//   s_last    : final item of the frame
interface heap_feeder_if #(
  parameter int KEY_WIDTH = 16,
  parameter int PAY_WIDTH = 14
) ();
  logic                 s_valid;
  logic                 s_ready;
  logic [KEY_WIDTH-1:0] s_key;
  logic [PAY_WIDTH-1:0] s_payload;
  logic                 s_last;

  modport master (output s_valid, output s_key, output s_payload, output s_last, input s_ready);
  modport slave  (input s_valid, input s_key, input s_payload, input s_last, output s_ready);
endinterface

// File: rtl/heap_feeder.sv
// Feeds one frame of keyed items into a systolic heap, then flushes it and waits for the
// drain window before signalling completion.
//   clk, rstn  : clock, asynchronous active-low reset
//   s          : item stream (heap_feeder_if slave)
//   heap_din   : packed {2'b00, payload, key} word, held until the next accepted item
//   heap_en    : one-cycle insert strobe
//   heap_init  : one-cycle frame-start strobe
//   heap_flush : one-cycle drain strobe
//   busy       : high whenever not idle
//   frame_done : one-cycle pulse after the drain window
//   item_cnt   : items accepted in the current frame (saturating)
module heap_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 16,
  parameter int NLEVELS    = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  heap_feeder_if.slave          s,
  output logic [DATA_WIDTH-1:0] heap_din,
  output logic                  heap_en,
  output logic                  heap_init,
  output logic                  heap_flush,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           item_cnt
);

  localparam int HEAP_SIZE  = (2 ** (NLEVELS + 1)) - 1;
  localparam int PAY_WIDTH  = DATA_WIDTH - 2 - KEY_WIDTH;
  localparam int FLUSH_WAIT = 2 * HEAP_SIZE + 4;
  localparam int CW         = $clog2(FLUSH_WAIT + 1);

  typedef enum logic [2:0] {StIdle, StInit, StRun, StGap, StFlush, StWait, StDone} state_e;

  state_e        state_q;
  logic          s_ready_q;
  logic          last_q;
  logic [CW-1:0] wait_cnt_q;

  assign s.s_ready = s_ready_q;

  // All outputs are registered: each is set on the transition into the state that owns it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      s_ready_q  <= 1'b0;
      last_q     <= 1'b0;
      wait_cnt_q <= '0;
      heap_din   <= '0;
      heap_en    <= 1'b0;
      heap_init  <= 1'b0;
      heap_flush <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      item_cnt   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // The waiting item is not consumed here; it is taken in RUN.
          if (s.s_valid) begin
            state_q   <= StInit;
            heap_init <= 1'b1;
            busy      <= 1'b1;
            item_cnt  <= '0;
          end
        end
        StInit: begin
          heap_init <= 1'b0;
          s_ready_q <= 1'b1;
          state_q   <= StRun;
        end
        StRun: begin
          if (s.s_valid) begin
            heap_din  <= {2'b00, s.s_payload[PAY_WIDTH-1:0], s.s_key[KEY_WIDTH-1:0]};
            last_q    <= s.s_last;
            s_ready_q <= 1'b0;
            heap_en   <= 1'b1;
            if (item_cnt != 16'hFFFF) item_cnt <= item_cnt + 16'd1;
            state_q   <= StGap;
          end
        end
        StGap: begin
          // Forced bubble: the heap needs two cycles per insert.
          heap_en <= 1'b0;
          if (last_q) begin
            heap_flush <= 1'b1;
            state_q    <= StFlush;
          end else begin
            s_ready_q <= 1'b1;
            state_q   <= StRun;
          end
        end
        StFlush: begin
          heap_flush <= 1'b0;
          wait_cnt_q <= CW'(FLUSH_WAIT - 1);
          state_q    <= StWait;
        end
        StWait: begin
          if (wait_cnt_q == '0) begin
            frame_done <= 1'b1;
            state_q    <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q - CW'(1);
          end
        end
        StDone: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state_q    <= StIdle;
        end
        default: begin
          state_q    <= StIdle;
          s_ready_q  <= 1'b0;
          heap_en    <= 1'b0;
          heap_init  <= 1'b0;
          heap_flush <= 1'b0;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
